// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, the per-pixel pipeline tag and the test-bar colour helper.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam logic [COORD_W-1:0] H_VIS        = 10'd640;
    localparam logic [COORD_W-1:0] H_FP         = 10'd16;
    localparam logic [COORD_W-1:0] H_SYNC       = 10'd96;
    localparam logic [COORD_W-1:0] H_BP         = 10'd48;
    localparam logic [COORD_W-1:0] H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [COORD_W-1:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [COORD_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [COORD_W-1:0] V_VIS        = 10'd480;
    localparam logic [COORD_W-1:0] V_FP         = 10'd10;
    localparam logic [COORD_W-1:0] V_SYNC       = 10'd2;
    localparam logic [COORD_W-1:0] V_BP         = 10'd33;
    localparam logic [COORD_W-1:0] V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [COORD_W-1:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [COORD_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Blank/sync state that travels with a coordinate until its colour returns.
    typedef struct packed {
        logic vis;
        logic hs_n;
        logic vs_n;
    } pix_tag_t;

    localparam pix_tag_t TAG_BLANK = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // Eight 80-pixel bars; bar index bits select B, G, R at full intensity.
    function automatic logic [11:0] bar_color(input logic [COORD_W-1:0] x);
        logic [2:0] bar;
        bar = 3'(x / 10'd80);
        return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered visible and active-low sync flags.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter logic [COORD_W-1:0] TOTAL      = H_TOTAL,
    parameter logic [COORD_W-1:0] SYNC_START = H_SYNC_START,
    parameter logic [COORD_W-1:0] SYNC_END   = H_SYNC_END,
    parameter logic [COORD_W-1:0] VIS        = H_VIS
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic               inc,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               visible,
    output logic               sync_n
);

    logic [COORD_W-1:0] count_nxt;

    always_comb begin
        wrap      = inc && (count == TOTAL - 10'd1);
        count_nxt = count;
        if (wrap) begin
            count_nxt = '0;
        end else if (inc) begin
            count_nxt = count + 10'd1;
        end
    end

    // Flags are registered from the next count so they line up with count and clear on reset.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            count   <= '0;
            visible <= 1'b0;
            sync_n  <= 1'b1;
        end else begin
            count   <= count_nxt;
            visible <= (count_nxt < VIS);
            sync_n  <= !((count_nxt >= SYNC_START) && (count_nxt < SYNC_END));
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator and DAC output stage running entirely on clk_50.
// Optional macro VGA_TEST_PATTERN_EN adds a test_mode input that replaces pixel_color with colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIPE_DLY = 2
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic [11:0]        pixel_color,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    output logic               pixel_clk,
    output logic               pix_en,
    output logic [COORD_W-1:0] X_pix,
    output logic [COORD_W-1:0] Y_pix,
    output logic               H_visible,
    output logic               V_visible,
    output logic               frame_start,
    output logic [3:0]         VGA_BUS_R,
    output logic [3:0]         VGA_BUS_G,
    output logic [3:0]         VGA_BUS_B,
    output logic               VGA_HS,
    output logic               VGA_VS
);

    logic        h_wrap;
    logic        v_wrap;
    logic        h_sync_n;
    logic        v_sync_n;
    logic        new_frame;
    pix_tag_t    tag_now;
    pix_tag_t    tag_out;
    pix_tag_t    tag_dly [PIPE_DLY];
    logic [11:0] color_src;

    // pix_en is high exactly in the cycle after pixel_clk rises.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            pixel_clk <= 1'b0;
            pix_en    <= 1'b0;
        end else begin
            pixel_clk <= ~pixel_clk;
            pix_en    <= ~pixel_clk;
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END),
        .VIS        (H_VIS)
    ) u_h_axis (
        .clk_50  (clk_50),
        .reset   (reset),
        .inc     (pix_en),
        .count   (X_pix),
        .wrap    (h_wrap),
        .visible (H_visible),
        .sync_n  (h_sync_n)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END),
        .VIS        (V_VIS)
    ) u_v_axis (
        .clk_50  (clk_50),
        .reset   (reset),
        .inc     (h_wrap),
        .count   (Y_pix),
        .wrap    (v_wrap),
        .visible (V_visible),
        .sync_n  (v_sync_n)
    );

    // Armed by reset or the last pixel of a frame, consumed by the first tick at (0,0).
    always_ff @(posedge clk_50) begin
        if (reset) begin
            new_frame <= 1'b1;
        end else if (h_wrap && v_wrap) begin
            new_frame <= 1'b1;
        end else if (pix_en) begin
            new_frame <= 1'b0;
        end
    end

    assign frame_start = pix_en && new_frame;

    assign tag_now = '{vis: H_visible && V_visible, hs_n: h_sync_n, vs_n: v_sync_n};
    assign tag_out = tag_dly[PIPE_DLY-1];

    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                tag_dly[i] <= TAG_BLANK;
            end
        end else if (pix_en) begin
            tag_dly[0] <= tag_now;
            for (int i = 1; i < PIPE_DLY; i++) begin
                tag_dly[i] <= tag_dly[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [COORD_W-1:0] x_dly [PIPE_DLY];

    // Bars follow the delayed X so they sit under the same sync as pixel_color would.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                x_dly[i] <= '0;
            end
        end else if (pix_en) begin
            x_dly[0] <= X_pix;
            for (int i = 1; i < PIPE_DLY; i++) begin
                x_dly[i] <= x_dly[i-1];
            end
        end
    end

    assign color_src = test_mode ? bar_color(x_dly[PIPE_DLY-1]) : pixel_color;
`else
    assign color_src = pixel_color;
`endif

    // Colour returned for a coordinate meets that coordinate's delayed tag on the same tick.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            {VGA_BUS_B, VGA_BUS_G, VGA_BUS_R} <= 12'h000;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else if (pix_en) begin
            VGA_HS <= tag_out.hs_n;
            VGA_VS <= tag_out.vs_n;
            if (tag_out.vis) begin
                {VGA_BUS_B, VGA_BUS_G, VGA_BUS_R} <= color_src;
            end else begin
                {VGA_BUS_B, VGA_BUS_G, VGA_BUS_R} <= 12'h000;
            end
        end
    end

endmodule
